// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//   Shared types and constants for the bit-serial datapath blocks.
//   - collect_state_t : state encoding of the serial word collector FSM
//   - SER_WIDTH       : default serial word width in bits
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } collect_state_t;

  localparam int SER_WIDTH = 8;

endpackage : serial_pkg

// File: rtl/serial_word_collector.sv
// ---------------------------------------------------------------------------
// serial_word_collector
//   Collects an LSB-first serial bit stream into a parallel WIDTH-bit word,
//   presents it on a valid/ready handshake and pulses frame_err on framing
//   violations (stray bit outside a word, or a new start-of-frame mid-word).
//
// Ports
//   clock       in   1      single clock, all state updates on posedge
//   reset       in   1      synchronous, active-high
//   bit_in      in   1      serial data bit, LSB first
//   bit_valid   in   1      bit_in valid this cycle
//   bit_sof     in   1      bit_in is bit 0 of a new word
//   bit_ready   out  1      collector accepts a bit this cycle
//   word_out    out  WIDTH  assembled word, bit i = i-th bit received
//   word_valid  out  1      word_out holds a complete word
//   word_ready  in   1      consumer takes the word this cycle
//   frame_err   out  1      one-cycle pulse per framing violation
// ---------------------------------------------------------------------------
module serial_word_collector
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             bit_sof,
  output logic             bit_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err
);

  localparam int                 COUNT_W  = $clog2(WIDTH + 1);
  localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(WIDTH);
  localparam logic [COUNT_W-1:0] ONE_CNT  = COUNT_W'(1);

  collect_state_t     r_state;
  logic [COUNT_W-1:0] r_count;
  // Only the upper WIDTH-1 bits need storing: the oldest bit is pushed out by
  // the very beat that completes the word, which loads word_out directly
  // from the shifted value.
  logic [WIDTH-2:0]   r_shift;
  logic [WIDTH-1:0]   r_word_out;
  logic               r_word_valid;
  logic               r_frame_err;

  collect_state_t     w_state_n;
  logic [COUNT_W-1:0] w_count_n;
  logic [COUNT_W-1:0] w_count_inc;
  logic [WIDTH-1:0]   w_shift_in;
  logic               w_beat;
  logic               w_shift_load;
  logic               w_word_load;
  logic               w_valid_n;
  logic               w_err_n;

  // In HOLD the collector can only take a bit when the word leaves in the
  // same cycle, which is what makes zero-bubble back-to-back words possible.
  assign bit_ready   = (r_state == HOLD) ? word_ready : 1'b1;
  assign w_beat      = bit_valid & bit_ready;
  assign w_shift_in  = {bit_in, r_shift};
  assign w_count_inc = r_count + ONE_CNT;

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves it unassigned -- otherwise a latch is inferred.
  always_comb begin
    w_state_n    = r_state;
    w_count_n    = r_count;
    w_shift_load = 1'b0;
    w_word_load  = 1'b0;
    w_valid_n    = r_word_valid;
    w_err_n      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_beat) begin
          if (bit_sof) begin
            w_shift_load = 1'b1;
            w_count_n    = ONE_CNT;
            w_state_n    = COLLECT;
          end else begin
            w_err_n = 1'b1;  // stray bit, dropped
          end
        end
      end

      COLLECT: begin
        if (w_beat) begin
          w_shift_load = 1'b1;
          if (bit_sof) begin
            // Restart: stale partial bits are shifted out before the new word
            // completes, so the shift register needs no clearing.
            w_err_n   = 1'b1;
            w_count_n = ONE_CNT;
          end else if (w_count_inc == LAST_CNT) begin
            w_word_load = 1'b1;
            w_valid_n   = 1'b1;
            w_count_n   = '0;
            w_state_n   = HOLD;
          end else begin
            w_count_n = w_count_inc;
          end
        end
      end

      HOLD: begin
        if (word_ready) begin
          w_valid_n = 1'b0;
          w_state_n = IDLE;
          if (w_beat) begin
            if (bit_sof) begin
              w_shift_load = 1'b1;
              w_count_n    = ONE_CNT;
              w_state_n    = COLLECT;
            end else begin
              w_err_n = 1'b1;
            end
          end
        end
      end

      default: w_state_n = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_count      <= w_count_n;
      r_word_valid <= w_valid_n;
      r_frame_err  <= w_err_n;
      if (w_word_load) r_word_out <= w_shift_in;
    end
  end

  // NOTE: the shift register is pure datapath and is left without reset; it
  // is fully overwritten before any of its bits can reach word_out.
  always_ff @(posedge clock) begin
    if (w_shift_load) r_shift <= w_shift_in[WIDTH-1:1];
  end

  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;
  assign frame_err  = r_frame_err;

endmodule : serial_word_collector

// File: tb/tb_serial_word_collector.sv
// ---------------------------------------------------------------------------
// tb_serial_word_collector
//   Directed self-checking bench for serial_word_collector (WIDTH = 8).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_serial_word_collector;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic         bit_in;
  logic         bit_valid;
  logic         bit_sof;
  logic         bit_ready;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready;
  logic         frame_err;

  int n_pass  = 0;
  int n_total = 0;
  int err_cycles = 0;  // number of cycles frame_err was seen high
  int err_mark;

  serial_word_collector #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_sof    (bit_sof),
    .bit_ready  (bit_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_err  (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && frame_err) err_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sof);
    bit_valid = 1'b1;
    bit_in    = b;
    bit_sof   = sof;
    tick();
    bit_valid = 1'b0;
    bit_sof   = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    for (int i = 0; i < W; i++) begin
      send_bit(w[i], i == 0);
      if (i < W - 1) begin
        for (int g = 0; g < gap; g++) tick();
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    bit_sof    = 1'b0;
    word_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_out",   32'(word_out),   32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_bit_ready",  32'(bit_ready),  32'd1);
    reset = 1'b0;

    // 1: 0xA5 with consumer ready
    send_word(8'hA5, 0);
    check("t1_valid", 32'(word_valid), 32'd1);
    check("t1_word",  32'(word_out),   32'h A5);
    tick();
    check("t1_valid_fall", 32'(word_valid), 32'd0);
    word_ready = 1'b0;
    #1;
    check("t1_idle_ready", 32'(bit_ready), 32'd1);
    word_ready = 1'b1;

    // 2: negator output 0xFA with one-cycle gaps
    err_mark = err_cycles;
    send_word(8'hFA, 1);
    check("t2_valid", 32'(word_valid), 32'd1);
    check("t2_word",  32'(word_out),   32'h FA);
    tick();
    check("t2_no_err", 32'(err_cycles - err_mark), 32'd0);

    // 3: consumer stalls with bit_valid held high
    err_mark   = err_cycles;
    word_ready = 1'b0;
    send_word(8'h3C, 0);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("t3_bit_ready", 32'(bit_ready),  32'd0);
      check("t3_valid",     32'(word_valid), 32'd1);
      check("t3_word",      32'(word_out),   32'h 3C);
      tick();
    end
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    word_ready = 1'b1;
    tick();
    check("t3_handoff", 32'(word_valid), 32'd0);
    check("t3_no_err",  32'(err_cycles - err_mark), 32'd0);

    // 4: back-to-back 0x01 then 0x80, second sof during handoff
    err_mark = err_cycles;
    send_word(8'h01, 0);
    check("t4_valid_a",  32'(word_valid), 32'd1);
    check("t4_word_a",   32'(word_out),   32'h 01);
    check("t4_ready_a",  32'(bit_ready),  32'd1);
    send_word(8'h80, 0);
    check("t4_valid_b",  32'(word_valid), 32'd1);
    check("t4_word_b",   32'(word_out),   32'h 80);
    tick();
    check("t4_no_err",   32'(err_cycles - err_mark), 32'd0);

    // 5: sof after 3 bits, then a full 0x5A
    err_mark = err_cycles;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(8'h5A, 0);
    check("t5_word",     32'(word_out),   32'h 5A);
    check("t5_valid",    32'(word_valid), 32'd1);
    check("t5_err_once", 32'(err_cycles - err_mark), 32'd1);
    tick();
    // stray bit in IDLE
    err_mark = err_cycles;
    send_bit(1'b1, 1'b0);
    check("t5_idle_err",      32'(frame_err),  32'd1);
    tick();
    check("t5_idle_err_fall", 32'(frame_err),  32'd0);
    check("t5_idle_no_word",  32'(word_valid), 32'd0);
    send_word(8'h0F, 0);
    check("t5_word_after",    32'(word_out),   32'h 0F);
    // handoff plus a beat without sof
    send_bit(1'b1, 1'b0);
    check("t5_hold_err",   32'(frame_err),  32'd1);
    check("t5_hold_valid", 32'(word_valid), 32'd0);
    check("t5_err_total",  32'(err_cycles - err_mark), 32'd1);
    tick();
    check("t5_hold_idle",  32'(frame_err),  32'd0);

    // 6: reset in the middle of a word
    err_mark = err_cycles;
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", 32'(word_valid), 32'd0);
    check("t6_rst_word",  32'(word_out),   32'd0);
    check("t6_rst_ready", 32'(bit_ready),  32'd1);
    reset = 1'b0;
    send_word(8'hFF, 0);
    check("t6_valid", 32'(word_valid), 32'd1);
    check("t6_word",  32'(word_out),   32'h FF);
    tick();
    check("t6_no_err", 32'(err_cycles - err_mark), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_serial_word_collector
